slv_guard_rst_ctrl: RTL



---
 rtl/slv_guard_rst_pkg.sv | 28 ++
 rtl/slv_guard_rst_ctrl_if.sv | 38 +++
 rtl/slv_guard_rst_timer.sv | 41 ++++
 rtl/slv_guard_rst_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/slv_guard_rst_pkg.sv
// -----------------------------------------------------------------------------
// slv_guard_rst_pkg
// Shared types for the subordinate-guard reset sequencer.
//   rst_state_e : sequencer FSM states (IDLE, ASSERT, RECOVER, ACK)
//   ST_*_ENC    : raw encodings of those states, for anyone probing the
//                 state register outside the enum type
//   state_isolates() : true for every state in which the bus stays isolated
// -----------------------------------------------------------------------------
package slv_guard_rst_pkg;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_ASSERT_ENC  = 2'd1;
    localparam logic [1:0] ST_RECOVER_ENC = 2'd2;
    localparam logic [1:0] ST_ACK_ENC     = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE_ENC,
        ASSERT  = ST_ASSERT_ENC,
        RECOVER = ST_RECOVER_ENC,
        ACK     = ST_ACK_ENC
    } rst_state_e;

    // Isolation covers the whole sequence, including the ACK hand-back.
    function automatic logic state_isolates(input rst_state_e s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/slv_guard_rst_ctrl_if.sv
// -----------------------------------------------------------------------------
// slv_guard_rst_ctrl_if
// Control bundle between the guard, the reset sequencer and the guarded
// subordinate.
//   rst_req_i  : level reset request from the guard
//   sub_rst_no : active-low reset into the guarded subordinate
//   isolate_o  : bus isolation while a sequence is in progress
//   rst_stat_o : reset-done status back to the guard's reset-clear input
//   busy_o     : sequencer is not idle
// Modports:
//   slave  : the sequencer (consumes the request, drives the rest)
//   master : the guard side / environment
// -----------------------------------------------------------------------------
interface slv_guard_rst_ctrl_if;

    logic rst_req_i;
    logic sub_rst_no;
    logic isolate_o;
    logic rst_stat_o;
    logic busy_o;

    modport slave (
        input  rst_req_i,
        output sub_rst_no,
        output isolate_o,
        output rst_stat_o,
        output busy_o
    );

    modport master (
        output rst_req_i,
        input  sub_rst_no,
        input  isolate_o,
        input  rst_stat_o,
        input  busy_o
    );

endinterface

// File: rtl/slv_guard_rst_timer.sv
// -----------------------------------------------------------------------------
// slv_guard_rst_timer
// Loadable down-counter shared by the hold and recovery phases.
// A load value of 0 is clamped to 1, so a loaded count never wraps.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset (count -> 0)
//   load_i       : load clamp(load_val_i); has priority over dec_i
//   load_val_i   : requested cycle count
//   dec_i        : decrement by one (holds at 0)
//   last_o       : count is exactly 1, i.e. this is the final cycle
// -----------------------------------------------------------------------------
module slv_guard_rst_timer #(
    parameter int CntWidth = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [CntWidth-1:0] load_val_i,
    input  logic                dec_i,
    output logic                last_o
);

    logic [CntWidth-1:0] cnt_q;

    function automatic logic [CntWidth-1:0] clamp_min1(input logic [CntWidth-1:0] v);
        return (v == '0) ? CntWidth'(1) : v;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= clamp_min1(load_val_i);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CntWidth'(1);
        end
    end

    assign last_o = (cnt_q == CntWidth'(1));

endmodule

// File: rtl/slv_guard_rst_ctrl.sv
// -----------------------------------------------------------------------------
// slv_guard_rst_ctrl
// Reset sequencer downstream of the subordinate guard. On a level request it
// pulls the subordinate's active-low reset for max(hold,1) cycles, keeps the
// bus isolated for a further max(recover,1) cycles, then raises reset-done
// until the guard drops its request.
//
// Parameters:
//   CntWidth    : width of hold/recover counters and config inputs
//   EvtCntWidth : width of the reset-event counter
// Ports:
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   ctrl (slave)       : rst_req_i in; sub_rst_no, isolate_o, rst_stat_o,
//                        busy_o out (see slv_guard_rst_ctrl_if)
//   hold_cycles_i      : reset-low duration, sampled when a sequence starts
//   recover_cycles_i   : isolation after release, sampled at end of hold
//   evt_cnt_o          : saturating count of sequences started
//   evt_ovf_o          : sticky, a start was seen while the count was full
//
// Build option:
//   SLV_GUARD_RST_EVT_CNT_EN - when defined the event counter and overflow
//   flag are built; otherwise both outputs are tied to 0.
//
// All outputs decode registered state only; there is no path from
// rst_req_i or the config inputs to any output within a cycle.
// -----------------------------------------------------------------------------
module slv_guard_rst_ctrl
    import slv_guard_rst_pkg::*;
#(
    parameter int CntWidth    = 10,
    parameter int EvtCntWidth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    slv_guard_rst_ctrl_if.slave    ctrl,
    input  logic [CntWidth-1:0]    hold_cycles_i,
    input  logic [CntWidth-1:0]    recover_cycles_i,
    output logic [EvtCntWidth-1:0] evt_cnt_o,
    output logic                   evt_ovf_o
);

    rst_state_e          state_q;
    rst_state_e          state_d;
    logic                tmr_load;
    logic                tmr_dec;
    logic [CntWidth-1:0] tmr_val;
    logic                tmr_last;

    // One timer serves both timed phases: the recovery count is loaded on
    // the same edge that ends the hold phase.
    slv_guard_rst_timer #(
        .CntWidth (CntWidth)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .last_o     (tmr_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = hold_cycles_i;
        case (state_q)
            IDLE: begin
                if (ctrl.rst_req_i) begin
                    state_d  = ASSERT;
                    tmr_load = 1'b1;
                    tmr_val  = hold_cycles_i;
                end
            end
            // The request is deliberately ignored in the two timed phases:
            // a request that drops early still gets a complete sequence.
            ASSERT: begin
                if (tmr_last) begin
                    state_d  = RECOVER;
                    tmr_load = 1'b1;
                    tmr_val  = recover_cycles_i;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            RECOVER: begin
                tmr_dec = 1'b1;
                if (tmr_last) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!ctrl.rst_req_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ctrl.sub_rst_no = (state_q != ASSERT);
    assign ctrl.isolate_o  = state_isolates(state_q);
    assign ctrl.rst_stat_o = (state_q == ACK);
    assign ctrl.busy_o     = (state_q != IDLE);

`ifdef SLV_GUARD_RST_EVT_CNT_EN
    logic                   seq_start;
    logic [EvtCntWidth-1:0] evt_cnt_q;
    logic                   evt_ovf_q;

    assign seq_start = (state_q == IDLE) && ctrl.rst_req_i;

    // Saturating event count; an attempt to go past all-ones latches the
    // overflow flag until the next reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            evt_cnt_q <= '0;
            evt_ovf_q <= 1'b0;
        end else if (seq_start) begin
            if (&evt_cnt_q) begin
                evt_ovf_q <= 1'b1;
            end else begin
                evt_cnt_q <= evt_cnt_q + EvtCntWidth'(1);
            end
        end
    end

    assign evt_cnt_o = evt_cnt_q;
    assign evt_ovf_o = evt_ovf_q;
`else
    assign evt_cnt_o = '0;
    assign evt_ovf_o = 1'b0;
`endif

endmodule
